// File: rtl/reg_bank8.sv
// reg_bank8: eight 64-bit flop-based registers with byte-enabled writes,
// per-register valid bits and a saturating accepted-write counter.
// One register (ZERO_REG) can be hardwired to zero; ZERO_REG >= 8 disables it.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset (wins over every other input)
//   wr_en      write request this cycle
//   wr_addr    destination register 0-7
//   wr_data    64-bit write data
//   wr_be      byte enables, bit k covers wr_data[8k+7:8k]
//   clr_valid  clear all valid bits at the next edge
//   regs       packed register contents, regs[n] = register n (straight from flops)
//   valid      bit n set = register n written since last reset/clear
//   wr_count   accepted writes since reset, saturating at 16'hFFFF
module reg_bank8 #(
  parameter int unsigned ZERO_REG = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [63:0]       wr_data,
  input  logic [7:0]        wr_be,
  input  logic              clr_valid,
  output logic [7:0][63:0]  regs,
  output logic [7:0]        valid,
  output logic [15:0]       wr_count
);

  logic        wr_accept;
  logic [7:0]  addr_onehot;
  logic [7:0]  valid_d,    valid_q;
  logic [15:0] wr_count_d, wr_count_q;

  // A ZERO_REG of 8 or more never matches a 3-bit address, so the
  // zero register is disabled without a separate check.
  always_comb begin
    wr_accept = wr_en && (wr_be != 8'h00) && (32'(wr_addr) != ZERO_REG);
  end

  always_comb begin
    addr_onehot = 8'h00;
    addr_onehot[wr_addr] = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        // No storage: this register reads zero forever.
        assign regs[gi] = 64'h0;
      end else begin : g_store
        logic [63:0] reg_d, reg_q;

        always_comb begin
          reg_d = reg_q;
          if (wr_accept && addr_onehot[gi]) begin
            for (int b = 0; b < 8; b++) begin
              if (wr_be[b]) begin
                reg_d[8*b +: 8] = wr_data[8*b +: 8];
              end
            end
          end
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            reg_q <= 64'h0;
          end else begin
            reg_q <= reg_d;
          end
        end

        assign regs[gi] = reg_q;
      end
    end
  endgenerate

  // Clear first, then set: a write in the same cycle as clr_valid survives.
  always_comb begin
    valid_d = clr_valid ? 8'h00 : valid_q;
    if (wr_accept) begin
      valid_d = valid_d | addr_onehot;
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_accept && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 8'h00;
      wr_count_q <= 16'h0000;
    end else begin
      valid_q    <= valid_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign valid    = valid_q;
  assign wr_count = wr_count_q;

endmodule
